micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter CW_WIDTH, default 16, control-word width.
REQ-003 The block SHALL have parameter UPC_WIDTH, default 4, microprogram counter width; depth = 2**UPC_WIDTH.
REQ-004 The block SHALL have parameter OPC_WIDTH, default 7, opcode width.
REQ-005 The ports SHALL be:
  - clk  in  1  rising-edge clock
  - reset  in  1  async active-high reset
  - run  in  1  sequencer enable
  - opcode  in  OPC_WIDTH  current instruction opcode
  - load_en  in  1  table write strobe
  - load_sel  in  2  target table: 0 ucode, 1 dispatch1, 2 dispatch2, 3 ignored
  - load_addr  in  UPC_WIDTH  write index; dispatch tables use low 3 bits
  - load_data  in  CW_WIDTH+3  write data; dispatch tables use low UPC_WIDTH bits
  - override  in  1  forces control_word to override_word
  - override_word  in  CW_WIDTH  forced control word
  - control_word  out  CW_WIDTH  registered control word
  - upc  out  UPC_WIDTH  current microaddress
  - running  out  1  sequencer active
  - illegal  out  1  one-cycle pulse on undecodable opcode at dispatch

Function
REQ-006 The ucode entry SHALL be {wait[1], seq[1:0], cw[CW_WIDTH-1:0]}; seq values: 00 goto 0, 01 upc+1, 10 dispatch1, 11 dispatch2.
REQ-007 The opcode class SHALL be decoded as 0110011->0, 0000011->1, 0100011->2, 1100011->3, 0010011->4, and any other value->7 (illegal); when OPC_WIDTH>7, only the low 7 bits SHALL be decoded.
REQ-008 Each dispatch table SHALL have 8 entries of UPC_WIDTH bits, indexed by opcode class.
REQ-009 With run=1 and running=0 (start cycle), the block SHALL set running<=1 and control_word<=ucode[upc].cw, leaving upc unchanged.
REQ-010 With run=1 and running=1 (advance cycle), the block SHALL set upc<=next and control_word<=ucode[next].cw on the same edge.
REQ-011 upc+1 SHALL wrap from 2**UPC_WIDTH-1 to 0.
REQ-012 A dispatch with class 7 SHALL set next=0 and assert illegal for exactly that one cycle.
REQ-013 With run=0, the block SHALL set running<=0 and control_word<=0, and SHALL hold upc.
REQ-014 When load_en=1 and run=0, the block SHALL write load_data into the table selected by load_sel at load_addr.
REQ-015 When load_en=1 and run=1, the write SHALL be ignored.
REQ-016 A write and a start in the same cycle cannot occur because of REQ-015.
REQ-017 A write to the entry at the held upc SHALL be visible on the next start cycle.
REQ-018 When override=1, the control_word port SHALL show override_word combinationally.
REQ-019 Override SHALL NOT affect sequencing, upc, or the internal control-word register.

Reset
REQ-020 Reset SHALL set upc=0, control_word register=0, running=0, illegal=0, asynchronously.
REQ-021 Table contents SHALL be unaffected by reset.
REQ-022 Reset asserted mid-sequence SHALL take effect immediately.
REQ-023 After reset deassertion, the first run=1 cycle SHALL be a start cycle at upc 0.

Configuration
REQ-024 With macro MICROSEQ_STALL_EN defined, the block SHALL add input port mem_ready (1 bit).
REQ-025 With MICROSEQ_STALL_EN defined, an advance cycle whose current entry has wait=1 while mem_ready=0 SHALL hold upc and control_word.
REQ-026 With MICROSEQ_STALL_EN undefined, there SHALL be no mem_ready port, the wait bit SHALL be stored but ignored, and the block SHALL never stall.

Verification
REQ-027 Load ucode[0]={0,01,0x9408}, ucode[1]={0,10,0x0018}, disp1[0]=2, ucode[2]={0,00,0x0040}; run=1, opcode=0110011 -> control_word 0x9408, 0x0018, 0x0040, 0x9408 with upc 0,1,2,0.
REQ-028 Same program with opcode=1111111 -> at dispatch illegal=1 for one cycle, next upc=0.
REQ-029 Load ucode[15] with seq=01 and start at upc 15 -> next upc=0, with no X on control_word.
REQ-030 Drop run at upc=1 -> control_word=0 and upc holds 1; raise run -> start cycle reloads ucode[1].cw, then advance to the dispatch target.
REQ-031 override=1 with override_word=0xFFFF mid-sequence -> port reads 0xFFFF while upc keeps advancing; releasing override restores the sequenced value.
REQ-032 With MICROSEQ_STALL_EN, entry wait=1 and mem_ready=0 for 3 cycles -> upc held 3 cycles, advancing on the first mem_ready=1; assert reset during the stall -> upc=0, running=0 immediately.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer: loadable ucode and two opcode-class dispatch tables, registered control word.
// Define MICROSEQ_STALL_EN to add mem_ready and honour the per-entry wait bit.
module micro_sequencer #(
  parameter int CW_WIDTH  = 16,
  parameter int UPC_WIDTH = 4,
  parameter int OPC_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
`ifdef MICROSEQ_STALL_EN
  input  logic                  mem_ready,
`endif
  input  logic [OPC_WIDTH-1:0]  opcode,
  input  logic                  load_en,
  input  logic [1:0]            load_sel,
  input  logic [UPC_WIDTH-1:0]  load_addr,
  input  logic [CW_WIDTH+2:0]   load_data,
  input  logic                  override,
  input  logic [CW_WIDTH-1:0]   override_word,
  output logic [CW_WIDTH-1:0]   control_word,
  output logic [UPC_WIDTH-1:0]  upc,
  output logic                  running,
  output logic                  illegal
);
  localparam int DEPTH = 2**UPC_WIDTH;

  logic [CW_WIDTH+2:0]  ucode [DEPTH];
  logic [UPC_WIDTH-1:0] disp1 [8];
  logic [UPC_WIDTH-1:0] disp2 [8];

  logic [CW_WIDTH-1:0]  cw_reg, cw_d;
  logic [UPC_WIDTH-1:0] upc_d, next_upc;
  logic                 running_d, illegal_d, dispatch_bad;
  logic [2:0]           op_class;
  logic [1:0]           seq_cur;
  logic                 wait_cur, stall;

  // Tables are plain storage with no reset so a reset does not wipe the microprogram.
  always_ff @(posedge clk) begin
    if (load_en && !run) begin
      case (load_sel)
        2'd0:    ucode[load_addr]      <= load_data;
        2'd1:    disp1[load_addr[2:0]] <= load_data[UPC_WIDTH-1:0];
        2'd2:    disp2[load_addr[2:0]] <= load_data[UPC_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign seq_cur  = ucode[upc][CW_WIDTH +: 2];
  assign wait_cur = ucode[upc][CW_WIDTH+2];

`ifdef MICROSEQ_STALL_EN
  assign stall = wait_cur & ~mem_ready;
`else
  assign stall = wait_cur & 1'b0;
`endif

  always_comb begin
    case (opcode[6:0])
      7'b0110011: op_class = 3'd0;
      7'b0000011: op_class = 3'd1;
      7'b0100011: op_class = 3'd2;
      7'b1100011: op_class = 3'd3;
      7'b0010011: op_class = 3'd4;
      default:    op_class = 3'd7;
    endcase
  end

  always_comb begin
    next_upc     = '0;
    dispatch_bad = 1'b0;
    case (seq_cur)
      2'b00: next_upc = '0;
      2'b01: next_upc = UPC_WIDTH'(upc + 1'b1);
      2'b10: begin
        dispatch_bad = (op_class == 3'd7);
        next_upc     = dispatch_bad ? '0 : disp1[op_class];
      end
      default: begin
        dispatch_bad = (op_class == 3'd7);
        next_upc     = dispatch_bad ? '0 : disp2[op_class];
      end
    endcase
  end

  // running is the FSM state: idle (0) or sequencing (1); start cycles reload without moving upc.
  always_comb begin
    running_d = running;
    upc_d     = upc;
    cw_d      = cw_reg;
    illegal_d = 1'b0;
    if (!run) begin
      running_d = 1'b0;
      cw_d      = '0;
    end else if (!running) begin
      running_d = 1'b1;
      cw_d      = ucode[upc][CW_WIDTH-1:0];
    end else if (!stall) begin
      upc_d     = next_upc;
      cw_d      = ucode[next_upc][CW_WIDTH-1:0];
      illegal_d = dispatch_bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      upc     <= '0;
      cw_reg  <= '0;
      illegal <= 1'b0;
    end else begin
      running <= running_d;
      upc     <= upc_d;
      cw_reg  <= cw_d;
      illegal <= illegal_d;
    end
  end

  always_comb begin
    control_word = override ? override_word : cw_reg;
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer (default parameters).
// Stall checks are compiled in when MICROSEQ_STALL_EN is defined.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, load_en, override;
`ifdef MICROSEQ_STALL_EN
  logic        mem_ready;
`endif
  logic [6:0]  opcode;
  logic [1:0]  load_sel;
  logic [3:0]  load_addr;
  logic [18:0] load_data;
  logic [15:0] override_word, control_word;
  logic [3:0]  upc;
  logic        running, illegal;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef MICROSEQ_STALL_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .override(override),
    .override_word(override_word), .control_word(control_word),
    .upc(upc), .running(running), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [3:0] addr, input logic [18:0] data);
    load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
    step();
    load_en = 1'b0;
  endtask

  function automatic logic [18:0] ent(input logic w, input logic [1:0] s, input logic [15:0] c);
    return {w, s, c};
  endfunction

  // dispatch2 targets by class and the control word loaded at each target
  logic [6:0]  cls_op  [5] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
  logic [3:0]  cls_tgt [5] = '{4'd4, 4'd15, 4'd5, 4'd6, 4'd7};
  logic [15:0] cls_cw  [5] = '{16'h4444, 16'h7E7E, 16'h5555, 16'h6666, 16'h7777};

  initial begin
    reset = 1'b1; run = 1'b0; load_en = 1'b0; override = 1'b0;
    opcode = 7'b0110011; load_sel = 2'd0; load_addr = '0; load_data = '0;
    override_word = '0;
`ifdef MICROSEQ_STALL_EN
    mem_ready = 1'b1;
`endif
    step(); step();
    check("rst_upc", upc, 4'd0);
    check("rst_cw", control_word, 16'h0);
    check("rst_running", running, 1'b0);
    check("rst_illegal", illegal, 1'b0);

    for (int i = 0; i < 16; i++) load(2'd0, 4'(i), '0);
    for (int i = 0; i < 8; i++) begin
      load(2'd1, 4'(i), '0);
      load(2'd2, 4'(i), '0);
    end
    load(2'd0, 4'd0, ent(1'b0, 2'b01, 16'h9408));
    load(2'd0, 4'd1, ent(1'b0, 2'b10, 16'h0018));
    load(2'd1, 4'd0, 19'd2);
    load(2'd0, 4'd2, ent(1'b0, 2'b00, 16'h0040));
    for (int i = 0; i < 5; i++) begin
      load(2'd2, 4'(i), 19'(cls_tgt[i]));
      load(2'd0, cls_tgt[i], ent(1'b0, (cls_tgt[i] == 4'd15) ? 2'b01 : 2'b00, cls_cw[i]));
    end
    reset = 1'b0;
    step();

    // basic program with dispatch1
    run = 1'b1;
    step(); check("p_start_cw", control_word, 16'h9408); check("p_start_upc", upc, 4'd0);
    check("p_running", running, 1'b1);
    step(); check("p1_cw", control_word, 16'h0018); check("p1_upc", upc, 4'd1);
    step(); check("p2_cw", control_word, 16'h0040); check("p2_upc", upc, 4'd2);
    step(); check("p3_cw", control_word, 16'h9408); check("p3_upc", upc, 4'd0);

    // illegal opcode at dispatch
    opcode = 7'b1111111;
    step(); check("ill_pre", illegal, 1'b0); check("ill_pre_upc", upc, 4'd1);
    step(); check("ill_pulse", illegal, 1'b1); check("ill_upc", upc, 4'd0);
    check("ill_cw", control_word, 16'h9408);
    step(); check("ill_clear", illegal, 1'b0); check("ill_next_upc", upc, 4'd1);

    // drop run at upc 1, rewrite held entry, restart
    run = 1'b0;
    step(); check("stop_cw", control_word, 16'h0); check("stop_upc", upc, 4'd1);
    check("stop_running", running, 1'b0);
    load(2'd0, 4'd1, ent(1'b0, 2'b10, 16'h0A5A));
    opcode = 7'b0110011;
    run = 1'b1;
    step(); check("restart_cw", control_word, 16'h0A5A); check("restart_upc", upc, 4'd1);
    step(); check("restart_adv_upc", upc, 4'd2); check("restart_adv_cw", control_word, 16'h0040);

    // write while running must be dropped
    load(2'd0, 4'd0, ent(1'b0, 2'b01, 16'h1111));
    check("wr_run_upc", upc, 4'd0);
    step(); step();
    step(); check("wr_run_ignored", control_word, 16'h9408);

    // override is combinational and does not disturb sequencing
    override_word = 16'hFFFF; override = 1'b1;
    #1 check("ovr_now", control_word, 16'hFFFF);
    step(); check("ovr_hold", control_word, 16'hFFFF); check("ovr_upc", upc, 4'd1);
    override = 1'b0;
    #1 check("ovr_release", control_word, 16'h0A5A);

    // switch upc 1 to dispatch2 and walk every opcode class
    run = 1'b0;
    step();
    load(2'd0, 4'd1, ent(1'b0, 2'b11, 16'h0B0B));
    run = 1'b1;
    step(); check("d2_start", control_word, 16'h0B0B);
    for (int i = 0; i < 5; i++) begin
      opcode = cls_op[i];
      step(); check("cls_upc", upc, 32'(cls_tgt[i])); check("cls_cw", control_word, 32'(cls_cw[i]));
      step(); check("cls_back", upc, 4'd0);
      step();
    end

    // start at the last entry and wrap
    opcode = 7'b0000011;
    step(); check("top_upc", upc, 4'd15);
    run = 1'b0;
    step(); check("top_hold", upc, 4'd15); check("top_cw0", control_word, 16'h0);
    run = 1'b1;
    step(); check("top_start_cw", control_word, 16'h7E7E); check("top_start_upc", upc, 4'd15);
    step(); check("wrap_upc", upc, 4'd0); check("wrap_cw", control_word, 16'h9408);

    // asynchronous reset mid-sequence, tables survive
    step(); check("pre_rst_upc", upc, 4'd1);
    reset = 1'b1;
    #1 check("arst_upc", upc, 4'd0); check("arst_running", running, 1'b0);
    check("arst_cw", control_word, 16'h0);
    reset = 1'b0;
    step(); check("post_rst_start", control_word, 16'h9408); check("post_rst_upc", upc, 4'd0);

    // wait bit on upc 1
    run = 1'b0;
    step();
    load(2'd0, 4'd1, ent(1'b1, 2'b11, 16'h0B0B));
    opcode = 7'b0110011;
    run = 1'b1;
    step(); step(); check("w_at1", upc, 4'd1);
`ifdef MICROSEQ_STALL_EN
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_upc", upc, 4'd1); check("stall_cw", control_word, 16'h0B0B);
    end
    mem_ready = 1'b1;
    step(); check("stall_go", upc, 4'd4); check("stall_go_cw", control_word, 16'h4444);
    step(); step(); check("stall2_at1", upc, 4'd1);
    mem_ready = 1'b0;
    step(); check("stall2_hold", upc, 4'd1);
    reset = 1'b1;
    #1 check("stall_rst_upc", upc, 4'd0); check("stall_rst_running", running, 1'b0);
    reset = 1'b0;
`else
    step(); check("nowait_upc", upc, 4'd4); check("nowait_cw", control_word, 16'h4444);
`endif
    run = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
